cgra_tile_dma: RTL and testbench
================================

# cgra_tile_dma

DMA engine that moves word blocks between system memory and the row-banked CGRA tile memory. It sits directly upstream of the tile memory's external port and drives ext_addr/ext_bank_sel/ext_read/ext_write/ext_wdata, consuming ext_rdata/ext_valid. One command transfers `len` consecutive words in either direction between a byte-addressed system-memory region and one bank, starting at a word offset. Only one external request is outstanding at a time, so behaviour is fully deterministic.

## Interface
- DATA_WIDTH, 32, word width (system and tile)
- ADDR_WIDTH, 12, tile word-address width
- BANK_DEPTH, 1024, valid entries per bank
- SYS_AW, 32, system byte-address width
- LEN_WIDTH, 12, transfer-length width (words)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_dir  in  1  0 = load (sys→tile), 1 = store (tile→sys)
- cmd_sys_addr  in  SYS_AW  system byte address, word aligned
- cmd_tile_addr  in  ADDR_WIDTH  starting word in bank
- cmd_bank  in  2  target bank
- cmd_len  in  LEN_WIDTH  word count
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at command completion
- error  out  1  valid with done; range violation
- mem_req_valid / mem_req_ready  out / in  1  system request handshake
- mem_req_write  out  1  1 = write
- mem_req_addr  out  SYS_AW  byte address
- mem_req_wdata  out  DATA_WIDTH  store data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  DATA_WIDTH  read data
- ext_addr  out  ADDR_WIDTH  to tile memory
- ext_bank_sel  out  2  to tile memory
- ext_read, ext_write  out  1  one-cycle strobes, never both high
- ext_wdata  out  DATA_WIDTH  to tile memory
- ext_rdata  in  DATA_WIDTH  from tile memory
- ext_valid  in  1  from tile memory, one cycle after ext_read

## Operation
- States: IDLE, LD_REQ, LD_WAIT, LD_WR, ST_RD, ST_CAP, ST_REQ, DONE.
- IDLE: on cmd_valid && cmd_ready latch all cmd fields; remaining ← cmd_len.
  - cmd_len == 0 → DONE, error = 0, no accesses.
  - cmd_tile_addr + cmd_len > BANK_DEPTH (computed at ADDR_WIDTH+1 / LEN_WIDTH+1 bits, no wrap) → DONE, error = 1, no accesses.
  - Otherwise cmd_dir = 0 → LD_REQ; cmd_dir = 1 → ST_RD.
- LD_REQ: mem_req_valid = 1, write = 0, addr = current sys addr; on ready → LD_WAIT.
- LD_WAIT: on mem_rsp_valid, capture rdata → LD_WR.
- LD_WR: ext_write = 1 with current bank/tile addr and captured data. Then sys addr += 4, tile addr += 1, remaining −= 1. remaining becomes 0 → DONE, else → LD_REQ.
- ST_RD: ext_read = 1 for one cycle → ST_CAP.
- ST_CAP: capture ext_rdata when ext_valid (always high here given the tile contract) → ST_REQ.
- ST_REQ: mem_req_valid = 1, write = 1, wdata = captured word; on ready, advance pointers/remaining as in LD_WR, then → DONE or ST_RD.
- DONE: done = 1 for one cycle, error as determined → IDLE.
- mem_req_* fields are held stable while valid && !ready.
- mem_rsp_valid outside LD_WAIT is ignored. Responses never arrive in the same cycle as their request handshake.
- New commands are not accepted until IDLE. A cmd_valid held through DONE is accepted on the first IDLE cycle.
- sys addr wraps modulo 2^SYS_AW; error does not cover it.

## Timing
- Reset: state IDLE; cmd_ready 1; busy, done, error, mem_req_valid, mem_req_write, ext_read, ext_write 0; all address/data outputs 0.
- Reset mid-transfer aborts immediately with no done pulse. Partial tile writes remain.
- Outputs are registered from the state and datapath registers; strobes are Moore outputs of their state.
- Load per word with ready = 1 and response latency L: 1 (REQ) + L (WAIT) + 1 (WR) cycles. Minimum is 3.
- Store per word with ready = 1: exactly 3 cycles (RD, CAP, REQ).
- Command accept to done: 1 + Σ(per-word) cycles; len = 0 or error gives done 1 cycle after accept.
- busy is high from the cycle after accept through the DONE cycle.

## Test plan
- Load: cmd_dir = 0, sys 0x1000, bank 2, tile 5, len 4, memory returns 0xA0..0xA3 at latency 1 → ext_write at addr 5..8, bank 2, data 0xA0..0xA3; done after 13 cycles; error = 0.
- Store: preload bank 1 words 0..2 = 0x11, 0x22, 0x33; cmd_dir = 1, sys 0x2000, len 3 → writes to 0x2000/0x2004/0x2008 with those data; done 10 cycles after accept.
- Backpressure: mem_req_ready held low 5 cycles in LD_REQ → request fields stable, no ext_write until response; overall completion delayed by 5.
- Range error: tile 1020, len 8 → done + error = 1 in the cycle after accept; zero ext/mem strobes. len = 0 → done, error = 0.
- Reset mid-load after 2 of 4 words → all strobes 0 and cmd_ready = 1 next cycle; no done pulse; a new command is then accepted normally.
- Back-to-back: cmd_valid held continuously with two commands → second accepted the cycle after the first's done pulse; spurious mem_rsp_valid while in IDLE is ignored.

Source files
------------

// File: rtl/cgra_tile_dma.sv
// Block DMA between byte-addressed system memory and one bank of the CGRA tile memory.
// Only one external request is in flight; every output decodes from state/datapath registers.
module cgra_tile_dma #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned BANK_DEPTH = 1024,
   parameter int unsigned SYS_AW     = 32,
   parameter int unsigned LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // command
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_dir,
   input  logic [SYS_AW-1:0]     cmd_sys_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_tile_addr,
   input  logic [1:0]            cmd_bank,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   // system memory
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [SYS_AW-1:0]     mem_req_addr,
   output logic [DATA_WIDTH-1:0] mem_req_wdata,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
   // tile memory external port
   output logic [ADDR_WIDTH-1:0] ext_addr,
   output logic [1:0]            ext_bank_sel,
   output logic                  ext_read,
   output logic                  ext_write,
   output logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic [DATA_WIDTH-1:0] ext_rdata,
   input  logic                  ext_valid
);

   // One extra bit so tile_addr + len cannot wrap before the bank-depth compare.
   localparam int unsigned SumW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StLdReq,
      StLdWait,
      StLdWr,
      StStRd,
      StStCap,
      StStReq,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [SYS_AW-1:0]     sys_addr_q, sys_addr_d;
   logic [ADDR_WIDTH-1:0] tile_addr_q, tile_addr_d;
   logic [1:0]            bank_q, bank_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  err_q, err_d;

   logic [SumW-1:0]       range_end;
   logic                  range_over;
   logic                  last_word;
   logic                  advance;

   assign range_end  = SumW'(cmd_tile_addr) + SumW'(cmd_len);
   assign range_over = range_end > SumW'(BANK_DEPTH);
   assign last_word  = (rem_q == LEN_WIDTH'(1));

   always_comb begin
      state_d     = state_q;
      sys_addr_d  = sys_addr_q;
      tile_addr_d = tile_addr_q;
      bank_d      = bank_q;
      rem_d       = rem_q;
      data_d      = data_q;
      err_d       = err_q;
      advance     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               sys_addr_d  = cmd_sys_addr;
               tile_addr_d = cmd_tile_addr;
               bank_d      = cmd_bank;
               rem_d       = cmd_len;
               err_d       = 1'b0;
               if (cmd_len == '0) begin
                  state_d = StDone;
               end else if (range_over) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = cmd_dir ? StStRd : StLdReq;
               end
            end
         end
         StLdReq: begin
            if (mem_req_ready) state_d = StLdWait;
         end
         StLdWait: begin
            if (mem_rsp_valid) begin
               data_d  = mem_rsp_rdata;
               state_d = StLdWr;
            end
         end
         StLdWr: begin
            advance = 1'b1;
            state_d = last_word ? StDone : StLdReq;
         end
         StStRd: begin
            state_d = StStCap;
         end
         StStCap: begin
            if (ext_valid) begin
               data_d  = ext_rdata;
               state_d = StStReq;
            end
         end
         StStReq: begin
            if (mem_req_ready) begin
               advance = 1'b1;
               state_d = last_word ? StDone : StStRd;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (advance) begin
         sys_addr_d  = sys_addr_q + SYS_AW'(4);
         tile_addr_d = tile_addr_q + ADDR_WIDTH'(1);
         rem_d       = rem_q - LEN_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sys_addr_q  <= '0;
         tile_addr_q <= '0;
         bank_q      <= '0;
         rem_q       <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sys_addr_q  <= sys_addr_d;
         tile_addr_q <= tile_addr_d;
         bank_q      <= bank_d;
         rem_q       <= rem_d;
         data_q      <= data_d;
         err_q       <= err_d;
      end
   end

   // Request fields come straight from registers, so they hold while the handshake stalls.
   assign cmd_ready     = (state_q == StIdle);
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign error         = (state_q == StDone) && err_q;
   assign mem_req_valid = (state_q == StLdReq) || (state_q == StStReq);
   assign mem_req_write = (state_q == StStReq);
   assign mem_req_addr  = sys_addr_q;
   assign mem_req_wdata = data_q;
   assign ext_read      = (state_q == StStRd);
   assign ext_write     = (state_q == StLdWr);
   assign ext_addr      = tile_addr_q;
   assign ext_bank_sel  = bank_q;
   assign ext_wdata     = data_q;

endmodule

// File: tb/tb_cgra_tile_dma.sv
// Bench for cgra_tile_dma: system-memory and tile-memory models plus a transfer-level
// reference model; directed plan steps followed by randomized commands.
module tb_cgra_tile_dma;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_dir;
   logic [31:0] cmd_sys_addr;
   logic [11:0] cmd_tile_addr;
   logic [1:0]  cmd_bank;
   logic [11:0] cmd_len;
   logic        busy, done, error;
   logic        mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic [11:0] ext_addr;
   logic [1:0]  ext_bank_sel;
   logic        ext_read, ext_write;
   logic [31:0] ext_wdata, ext_rdata;
   logic        ext_valid;

   always #5 clk = ~clk;

   cgra_tile_dma dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_dir       (cmd_dir),
      .cmd_sys_addr  (cmd_sys_addr),
      .cmd_tile_addr (cmd_tile_addr),
      .cmd_bank      (cmd_bank),
      .cmd_len       (cmd_len),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_write (mem_req_write),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .ext_addr      (ext_addr),
      .ext_bank_sel  (ext_bank_sel),
      .ext_read      (ext_read),
      .ext_write     (ext_write),
      .ext_wdata     (ext_wdata),
      .ext_rdata     (ext_rdata),
      .ext_valid     (ext_valid)
   );

   typedef struct packed {logic [1:0] bank; logic [11:0] addr; logic [31:0] data;} ext_wr_t;
   typedef struct packed {logic [31:0] addr; logic [31:0] data;} mem_wr_t;

   ext_wr_t     got_ext[$], exp_ext[$];
   mem_wr_t     got_mem[$], exp_mem[$];
   logic [31:0] sys_init[logic [31:0]];
   logic [31:0] tile_mem[4][DEPTH];
   logic [31:0] ref_tile[4][DEPTH];
   bit          tile_init;

   int n_assert, n_fail;
   int arm_tok, arm_seen, cfg_lat, cfg_first, cfg_max, cfg_reqs;
   int stall_left, stall_cnt, hs_cnt, rsp_cnt, mem_rd_cnt, ext_rd_cnt;
   logic        rsp_v, spur;
   logic [31:0] rsp_rdata, rsp_buf;

   bit exp_err, exp_dir;
   int exp_words, exp_cyc, ext_base, mem_base, mrd_base, erd_base;

   assign mem_req_ready = (stall_left == 0);
   assign mem_rsp_valid = rsp_v | spur;
   assign mem_rsp_rdata = rsp_rdata;

   function automatic logic [31:0] f_tile(int b, int a);
      return (32'(b) * 32'h0100_0193) ^ (32'(a) * 32'h9E37_79B1);
   endfunction

   // System memory = initial image overlaid with every write seen so far.
   function automatic logic [31:0] sys_read(logic [31:0] a);
      for (int i = got_mem.size() - 1; i >= 0; i--)
         if (got_mem[i].addr == a) return got_mem[i].data;
      if (sys_init.exists(a)) return sys_init[a];
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // System memory: ready stalls chosen per request, read data after cfg_lat cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         rsp_v      <= 1'b0;
         rsp_cnt    <= 0;
         stall_left <= 0;
         stall_cnt  <= 0;
         hs_cnt     <= 0;
         arm_seen   <= arm_tok;
      end else begin
         rsp_v <= 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt <= rsp_cnt - 1;
            if (rsp_cnt == 1) begin
               rsp_v     <= 1'b1;
               rsp_rdata <= rsp_buf;
            end
         end
         if (arm_tok != arm_seen) begin
            arm_seen   <= arm_tok;
            hs_cnt     <= 0;
            stall_cnt  <= 0;
            stall_left <= (cfg_reqs == 0) ? 0 :
                          (cfg_first >= 0) ? cfg_first : int'($urandom_range(0, cfg_max));
         end else if (mem_req_valid) begin
            if (stall_left != 0) begin
               stall_left <= stall_left - 1;
               stall_cnt  <= stall_cnt + 1;
            end else begin
               hs_cnt <= hs_cnt + 1;
               if (hs_cnt + 1 < cfg_reqs) stall_left <= int'($urandom_range(0, cfg_max));
               if (mem_req_write) begin
                  got_mem.push_back({mem_req_addr, mem_req_wdata});
               end else begin
                  mem_rd_cnt <= mem_rd_cnt + 1;
                  if (cfg_lat <= 1) begin
                     rsp_v     <= 1'b1;
                     rsp_rdata <= sys_read(mem_req_addr);
                  end else begin
                     rsp_cnt <= cfg_lat - 1;
                     rsp_buf <= sys_read(mem_req_addr);
                  end
               end
            end
         end
      end
   end

   // Tile memory: contents survive reset, read data one cycle after ext_read.
   always @(posedge clk) begin
      if (!tile_init) begin
         for (int b = 0; b < 4; b++)
            for (int a = 0; a < DEPTH; a++) tile_mem[b][a] <= f_tile(b, a);
         tile_init <= 1'b1;
      end
      ext_valid <= rst_n && ext_read;
      if (ext_write) begin
         tile_mem[ext_bank_sel][ext_addr] <= ext_wdata;
         got_ext.push_back({ext_bank_sel, ext_addr, ext_wdata});
      end
      if (ext_read) begin
         ext_rdata  <= tile_mem[ext_bank_sel][ext_addr];
         ext_rd_cnt <= ext_rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model of one command, then offer it to the DUT (called at a negedge).
   task automatic start_cmd(input bit dir, input logic [31:0] sys, input int tile, input int bank,
                            input int len, input int lat, input int first, input int maxs);
      logic [31:0] a, d;
      exp_ext.delete();
      exp_mem.delete();
      exp_dir   = dir;
      exp_err   = (len != 0) && (tile + len > DEPTH);
      exp_words = exp_err ? 0 : len;
      for (int i = 0; i < exp_words; i++) begin
         a = sys + 32'(4 * i);
         if (!dir) begin
            d = sys_read(a);
            ref_tile[bank][tile + i] = d;
            exp_ext.push_back({2'(bank), 12'(tile + i), d});
         end else begin
            exp_mem.push_back({a, ref_tile[bank][tile + i]});
         end
      end
      exp_cyc   = 1 + exp_words * (dir ? 3 : 2 + lat);
      ext_base  = got_ext.size();
      mem_base  = got_mem.size();
      mrd_base  = mem_rd_cnt;
      erd_base  = ext_rd_cnt;
      cfg_lat   = lat;
      cfg_first = first;
      cfg_max   = maxs;
      cfg_reqs  = exp_words;
      arm_tok++;
      cmd_dir       = dir;
      cmd_sys_addr  = sys;
      cmd_tile_addr = 12'(tile);
      cmd_bank      = 2'(bank);
      cmd_len       = 12'(len);
      cmd_valid     = 1'b1;
   endtask

   task automatic wait_done(input string tag, input bit hold);
      int          cyc = 0;
      bit          seen = 0, prev_hold = 0, pw = 0;
      logic [31:0] pa = '0, pd = '0;
      int          n;
      @(posedge clk);
      while (cyc < 2000 && !seen) begin
         @(negedge clk);
         cyc++;
         spur = 1'b0;
         if (!hold) cmd_valid = 1'b0;
         check({tag, " rw_excl"}, 64'(ext_read & ext_write), 64'(0));
         check({tag, " busy"}, 64'(busy), 64'(1));
         if (prev_hold) begin
            check({tag, " hold_valid"}, 64'(mem_req_valid), 64'(1));
            check({tag, " hold_fields"}, {pw, pa, pd[30:0]},
                  {mem_req_write, mem_req_addr, mem_req_wdata[30:0]});
         end
         prev_hold = mem_req_valid && !mem_req_ready;
         pw = mem_req_write;
         pa = mem_req_addr;
         pd = mem_req_wdata;
         if (done) seen = 1;
      end
      check({tag, " done_seen"}, 64'(seen), 64'(1));
      check({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc + stall_cnt));
      check({tag, " error"}, 64'(error), 64'(exp_err));
      n = got_ext.size() - ext_base;
      check({tag, " ext_writes"}, 64'(n), 64'(exp_ext.size()));
      for (int i = 0; i < n && i < exp_ext.size(); i++)
         check({tag, " ext_wr"}, 64'(got_ext[ext_base + i]), 64'(exp_ext[i]));
      n = got_mem.size() - mem_base;
      check({tag, " mem_writes"}, 64'(n), 64'(exp_mem.size()));
      for (int i = 0; i < n && i < exp_mem.size(); i++)
         check({tag, " mem_wr"}, 64'(got_mem[mem_base + i]), 64'(exp_mem[i]));
      check({tag, " mem_reads"}, 64'(mem_rd_cnt - mrd_base), 64'(exp_dir ? 0 : exp_words));
      check({tag, " ext_reads"}, 64'(ext_rd_cnt - erd_base), 64'(exp_dir ? exp_words : 0));
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, " idle_done"}, 64'(done), 64'(0));
      check({tag, " idle_busy"}, 64'(busy), 64'(0));
      check({tag, " idle_ready"}, 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      logic [31:0] keep2, keep3, rsys;
      int          k, rt;
      bit          hit;
      rst_n         = 1'b0;
      cmd_valid     = 1'b0;
      cmd_dir       = 1'b0;
      cmd_sys_addr  = '0;
      cmd_tile_addr = '0;
      cmd_bank      = '0;
      cmd_len       = '0;
      spur          = 1'b0;
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < DEPTH; a++) ref_tile[b][a] = f_tile(b, a);

      repeat (3) @(negedge clk);
      check("rst cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst error", 64'(error), 64'(0));
      check("rst strobes", 64'({mem_req_valid, mem_req_write, ext_read, ext_write}), 64'(0));
      check("rst mem_addr", 64'(mem_req_addr), 64'(0));
      check("rst mem_wdata", 64'(mem_req_wdata), 64'(0));
      check("rst ext_addr", 64'({ext_bank_sel, ext_addr}), 64'(0));
      check("rst ext_wdata", 64'(ext_wdata), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Plan load: 0xA0..0xA3 from 0x1000 into bank 2 at word 5.
      for (int i = 0; i < 4; i++) sys_init[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      start_cmd(0, 32'h1000, 5, 2, 4, 1, 0, 0);
      wait_done("load", 0);
      idle_check("load");

      // Put 0x11/0x22/0x33 into bank 1 words 0..2, then store them to 0x2000.
      for (int i = 0; i < 3; i++) sys_init[32'h3000 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
      start_cmd(0, 32'h3000, 0, 1, 3, 2, 0, 0);
      wait_done("preload", 0);
      idle_check("preload");
      start_cmd(1, 32'h2000, 0, 1, 3, 1, 0, 0);
      wait_done("store", 0);
      idle_check("store");

      start_cmd(0, 32'h1000, 20, 3, 2, 1, 5, 0);
      wait_done("backpressure", 0);
      idle_check("backpressure");

      start_cmd(0, 32'h0100, 1020, 0, 8, 1, 0, 0);
      wait_done("range_ld", 0);
      idle_check("range_ld");
      start_cmd(1, 32'h0100, 1023, 3, 2, 1, 0, 0);
      wait_done("range_st", 0);
      idle_check("range_st");
      start_cmd(0, 32'h0100, 4000, 0, 0, 1, 0, 0);
      wait_done("len0", 0);
      idle_check("len0");
      start_cmd(1, 32'h7000, 1020, 0, 4, 1, 0, 0);
      wait_done("edge_fit", 0);
      idle_check("edge_fit");

      // Reset after two of four load words have reached the tile.
      keep2 = ref_tile[2][102];
      keep3 = ref_tile[2][103];
      start_cmd(0, 32'h4000, 100, 2, 4, 1, 0, 0);
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (got_ext.size() - ext_base >= 2) hit = 1;
      end
      check("rst_mid reached", 64'(hit), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid strobes", 64'({mem_req_valid, ext_read, ext_write}), 64'(0));
      check("rst_mid done", 64'({done, error}), 64'(0));
      check("rst_mid ready", 64'(cmd_ready), 64'(1));
      rst_n = 1'b1;
      ref_tile[2][102] = keep2;
      ref_tile[2][103] = keep3;
      @(negedge clk);
      check("rst_mid writes", 64'(got_ext.size() - ext_base), 64'(2));
      check("rst_mid w0", 64'(tile_mem[2][100]), 64'(ref_tile[2][100]));
      check("rst_mid w1", 64'(tile_mem[2][101]), 64'(ref_tile[2][101]));
      check("rst_mid w2", 64'(tile_mem[2][102]), 64'(keep2));
      start_cmd(0, 32'h1000, 300, 1, 2, 1, 0, 0);
      wait_done("after_rst", 0);
      idle_check("after_rst");

      // cmd_valid held high across two commands; spurious response while idle.
      start_cmd(1, 32'h5000, 0, 2, 2, 1, 0, 0);
      wait_done("b2b_first", 1);
      start_cmd(0, 32'h6000, 50, 0, 3, 3, 0, 0);
      @(negedge clk);
      check("b2b ready", 64'(cmd_ready), 64'(1));
      spur = 1'b1;
      wait_done("b2b_second", 0);
      idle_check("b2b_second");

      for (k = 0; k < 25; k++) begin
         rt   = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(0, 8))
                                             : int'($urandom_range(0, 1000));
         rsys = (k == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         start_cmd(1'($urandom_range(0, 1)), rsys, rt, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 6)), int'($urandom_range(1, 3)), -1,
                   int'($urandom_range(0, 2)));
         wait_done("rand", 0);
         idle_check("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
